// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader
//   Assembles 32-bit MIPS instruction words from symbolic requests and writes
//   them into instruction memory at a self-incrementing word address. It sits
//   between the boot/test loader and the IM write port.
// Ports
//   clk, rst            clock, synchronous active-high reset
//   start               synchronous restart of pointer/count/full
//   in_valid/in_ready   request handshake (transfer when both high)
//   is_r, sel           R-type FUNC (is_r=1) or OP (is_r=0)
//   rs, rt, rd, shamt   register / shift fields
//   imm, target         immediate and jump target fields
//   im_we/addr/wdata    IM write port (one strobe per legal request)
//   count, full         words written since reset/start, capacity reached
//   err                 one-cycle pulse for a rejected (illegal) request
module instr_encoder_loader #(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              is_r,
  input  logic [5:0]        sel,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err
);

  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  // count value just before the final write; writing from here fills IM
  localparam logic [ADDR_W:0]   LAST_CNT = {1'b0, {ADDR_W{1'b1}}};

  typedef enum logic {IDLE, WRITE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic              legal;
  logic [31:0]       word;
  logic              xfer;

  assign xfer = in_valid && in_ready;

  // Legality check and word assembly for the request currently presented.
  always_comb begin
    legal = 1'b0;
    word  = 32'h0;
    if (is_r) begin
      legal = sel inside {6'd0, 6'd2, 6'd3, 6'd4, 6'd6, 6'd7, 6'd8, 6'd12,
                          [6'd32:6'd39], 6'd42, 6'd43};
      case (sel)
        6'd0, 6'd2, 6'd3: word = {6'd0, 5'd0, rt, rd, shamt, sel};  // shift-imm: no rs
        6'd8:             word = {6'd0, rs, 15'd0, sel};             // JR: rs only
        6'd12:            word = 32'h0000_000C;                      // SYSCALL
        default:          word = {6'd0, rs, rt, rd, 5'd0, sel};
      endcase
    end else begin
      legal = sel inside {[6'd2:6'd15], 6'd32, 6'd33, 6'd35, 6'd36, 6'd37,
                          6'd40, 6'd41, 6'd43};
      case (sel)
        6'd2, 6'd3: word = {sel, target};
        6'd15:      word = {sel, 5'd0, rt, imm};                      // LUI
        6'd6, 6'd7: word = {sel, rs, 5'd0, imm};                      // BLEZ/BGTZ
        default:    word = {sel, rs, rt, imm};
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= BASE;
      count    <= '0;
      full     <= 1'b0;
      in_ready <= 1'b1;
      im_we    <= 1'b0;
      im_addr  <= BASE;
      im_wdata <= 32'h0;
      err      <= 1'b0;
    end else begin
      im_we <= 1'b0;
      err   <= 1'b0;
      if (start) begin
        // A write already on the port this cycle still lands; the pointer
        // and count restart instead of advancing. Concurrent transfers drop.
        state    <= IDLE;
        ptr      <= BASE;
        count    <= '0;
        full     <= 1'b0;
        in_ready <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (xfer) begin
              if (legal) begin
                state    <= WRITE;
                im_we    <= 1'b1;
                im_addr  <= ptr;
                im_wdata <= word;
                in_ready <= 1'b0;
              end else begin
                err <= 1'b1;
              end
            end
          end
          WRITE: begin
            state    <= IDLE;
            ptr      <= ptr + 1'b1;
            count    <= count + 1'b1;
            full     <= (count == LAST_CNT);
            // once full, stay closed until start/rst so the pointer never wraps
            in_ready <= (count != LAST_CNT);
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader with ADDR_W=2, BASE_ADDR=1 so the
// address wrap (1,2,3,0) and the full condition are reached quickly.
module tb_instr_encoder_loader;

  localparam int ADDR_W = 2;
  localparam int BASE   = 1;

  logic              clk = 1'b0;
  logic              rst, start, in_valid, is_r;
  logic [5:0]        sel;
  logic [4:0]        rs, rt, rd, shamt;
  logic [15:0]       imm;
  logic [25:0]       target;
  logic              in_ready, im_we, full, err;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;
  logic [ADDR_W:0]   count;

  int n_tests = 0;
  int n_fail  = 0;

  instr_encoder_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .is_r(is_r), .sel(sel), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .imm(imm),
    .target(target), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .count(count), .full(full), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_req(input logic r, input logic [5:0] s, input logic [4:0] a,
                         input logic [4:0] b, input logic [4:0] c, input logic [4:0] sh,
                         input logic [15:0] im, input logic [25:0] tg);
    is_r = r; sel = s; rs = a; rt = b; rd = c; shamt = sh; imm = im; target = tg;
  endtask

  // Present the current request, wait (bounded) for in_ready, transfer it.
  // Returns in the cycle right after the transfer edge.
  task automatic xfer();
    int n = 0;
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin tick(); n++; end
    chk("xfer_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  // Expect a write in the current cycle, then step into the next IDLE cycle.
  task automatic expect_write(input string tag, input logic [31:0] w,
                              input logic [ADDR_W-1:0] a);
    chk({tag, "_we"},    {31'd0, im_we},    32'd1);
    chk({tag, "_data"},  im_wdata,          w);
    chk({tag, "_addr"},  {30'd0, im_addr},  {30'd0, a});
    chk({tag, "_rdy"},   {31'd0, in_ready}, 32'd0);
    tick();
  endtask

  task automatic do_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  logic [31:0] b2b_word [4] = '{32'h3C05_1234, 32'h1860_0010, 32'h03E0_0008, 32'h0007_17C3};
  logic [1:0]  b2b_addr [4] = '{2'd1, 2'd2, 2'd3, 2'd0};

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0;
    set_req(1'b0, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
    tick(); tick();
    rst = 1'b0;

    // reset values
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_we",    {31'd0, im_we},    32'd0);
    chk("rst_addr",  {30'd0, im_addr},  32'd1);
    chk("rst_wdata", im_wdata,          32'd0);
    chk("rst_count", {29'd0, count},    32'd0);
    chk("rst_full",  {31'd0, full},     32'd0);
    chk("rst_err",   {31'd0, err},      32'd0);

    // ADD: shamt forced to zero
    set_req(1'b1, 6'd32, 5'd1, 5'd2, 5'd3, 5'd7, 16'h0, 26'h0);
    xfer();
    expect_write("add", 32'h0022_1820, 2'd1);
    chk("add_count", {29'd0, count}, 32'd1);
    chk("add_ready", {31'd0, in_ready}, 32'd1);

    // illegal OP 1 and illegal FUNC 5: err pulse, nothing written
    set_req(1'b0, 6'd1, 5'd1, 5'd1, 5'd1, 5'd1, 16'h1, 26'h1);
    xfer();
    chk("ill_op_err", {31'd0, err},   32'd1);
    chk("ill_op_we",  {31'd0, im_we}, 32'd0);
    tick();
    chk("ill_op_err_clr", {31'd0, err}, 32'd0);
    chk("ill_op_count", {29'd0, count}, 32'd1);
    set_req(1'b1, 6'd5, 5'd1, 5'd1, 5'd1, 5'd1, 16'h1, 26'h1);
    xfer();
    chk("ill_fn_err", {31'd0, err},   32'd1);
    chk("ill_fn_we",  {31'd0, im_we}, 32'd0);
    tick();
    chk("ill_fn_count", {29'd0, count}, 32'd1);

    // SLL: rs forced to zero; lands at the address the illegals did not consume
    set_req(1'b1, 6'd0, 5'd9, 5'd2, 5'd4, 5'd3, 16'h0, 26'h0);
    xfer();
    expect_write("sll", 32'h0002_20C0, 2'd2);

    // LW
    set_req(1'b0, 6'd35, 5'd29, 5'd8, 5'd0, 5'd0, 16'hFFFC, 26'h0);
    xfer();
    expect_write("lw", 32'h8FA8_FFFC, 2'd3);

    // JAL: last slot, address wraps to 0, then full
    set_req(1'b0, 6'd3, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h010_0000);
    xfer();
    expect_write("jal", 32'h0C10_0000, 2'd0);
    chk("full_count", {29'd0, count},    32'd4);
    chk("full_flag",  {31'd0, full},     32'd1);
    chk("full_ready", {31'd0, in_ready}, 32'd0);

    // fifth request is never accepted while full
    set_req(1'b0, 6'd8, 5'd1, 5'd1, 5'd0, 5'd0, 16'h5, 26'h0);
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("full_hold_we",    {31'd0, im_we},    32'd0);
      chk("full_hold_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;

    // start reopens; SYSCALL goes to BASE
    do_start();
    chk("start_full",  {31'd0, full},     32'd0);
    chk("start_count", {29'd0, count},    32'd0);
    chk("start_ready", {31'd0, in_ready}, 32'd1);
    set_req(1'b1, 6'd12, 5'd7, 5'd7, 5'd7, 5'd7, 16'hFFFF, 26'h3FF_FFFF);
    xfer();
    expect_write("syscall", 32'h0000_000C, 2'd1);

    // back-to-back with in_valid held: LUI, BLEZ, JR, SRA
    do_start();
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: set_req(1'b0, 6'd15, 5'd7,  5'd5, 5'd0, 5'd0,  16'h1234, 26'h0);
        1: set_req(1'b0, 6'd6,  5'd3,  5'd9, 5'd0, 5'd0,  16'h0010, 26'h0);
        2: set_req(1'b1, 6'd8,  5'd31, 5'd4, 5'd5, 5'd6,  16'h0,    26'h0);
        default: set_req(1'b1, 6'd3, 5'd1, 5'd7, 5'd2, 5'd31, 16'h0, 26'h0);
      endcase
      chk("b2b_ready", {31'd0, in_ready}, 32'd1);
      tick();
      chk("b2b_we",    {31'd0, im_we},    32'd1);
      chk("b2b_data",  im_wdata,          b2b_word[k]);
      chk("b2b_addr",  {30'd0, im_addr},  {30'd0, b2b_addr[k]});
      chk("b2b_wrdy",  {31'd0, in_ready}, 32'd0);
      tick();
    end
    in_valid = 1'b0;
    chk("b2b_count", {29'd0, count}, 32'd4);

    // start concurrent with a valid request in IDLE: request is dropped
    set_req(1'b1, 6'd32, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
    start = 1'b1; in_valid = 1'b1;
    tick();
    start = 1'b0; in_valid = 1'b0;
    chk("start_drop_we",    {31'd0, im_we}, 32'd0);
    chk("start_drop_count", {29'd0, count}, 32'd0);

    // rst during WRITE aborts everything
    xfer();
    chk("rstw_we_pre", {31'd0, im_we}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstw_we",    {31'd0, im_we},    32'd0);
    chk("rstw_count", {29'd0, count},    32'd0);
    chk("rstw_addr",  {30'd0, im_addr},  32'd1);
    chk("rstw_ready", {31'd0, in_ready}, 32'd1);
    chk("rstw_wdata", im_wdata,          32'd0);

    // start during WRITE: write at old address still appears, counters restart
    set_req(1'b1, 6'd32, 5'd1, 5'd2, 5'd3, 5'd7, 16'h0, 26'h0);
    xfer();
    expect_write("sw_add", 32'h0022_1820, 2'd1);
    set_req(1'b1, 6'd0, 5'd9, 5'd2, 5'd4, 5'd3, 16'h0, 26'h0);
    xfer();
    chk("sw_we",   {31'd0, im_we},   32'd1);
    chk("sw_addr", {30'd0, im_addr}, 32'd2);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("sw_count", {29'd0, count},    32'd0);
    chk("sw_ready", {31'd0, in_ready}, 32'd1);
    set_req(1'b0, 6'd35, 5'd29, 5'd8, 5'd0, 5'd0, 16'hFFFC, 26'h0);
    xfer();
    expect_write("sw_lw", 32'h8FA8_FFFC, 2'd1);
    chk("sw_count_after", {29'd0, count}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
